writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage of the GPU core. Latches Memory-stage results and drives the Decode-side
//  write ports: scalar/vector register write, condition-code update and PC redirect.
//  Also issues GPU commands over a valid/ready handshake and raises the GPU stall seen by
//  Decode/Fetch while a command is outstanding. Counts retired instructions.
// PARAMETERS
//  REG_WIDTH      16  scalar register / writeback data width
//  VREG_WIDTH     64  vector register width
//  VREG_ID_WIDTH  6   vector register index width
//  PC_WIDTH       16  program counter width
//  CNT_WIDTH      32  retired-instruction counter width
// PORTS
//  I_CLOCK            in   1              single core clock; all state updates on negedge (pipeline latch edge)
//  I_RESET_N          in   1              synchronous, active-low reset
//  I_LOCK             in   1              pipeline enable; 0 = hold state, all write enables forced 0
//  I_MW_Valid         in   1              Memory stage presents a valid instruction
//  I_IR               in   32             instruction word (opcode = IR[31:24])
//  I_DestRegIdx       in   4              scalar destination index
//  I_DestVRegIdx      in   VREG_ID_WIDTH  vector destination index
//  I_DestWrite        in   1              instruction writes scalar register
//  I_DestVWrite       in   1              instruction writes vector register
//  I_CCWrite          in   1              instruction updates CC
//  I_Data             in   REG_WIDTH      scalar result
//  I_VecData          in   VREG_WIDTH     vector result / GPU command payload
//  I_BranchTaken      in   1              control transfer resolved taken
//  I_BranchPC         in   PC_WIDTH       redirect target
//  I_GPUCmdReady      in   1              GPU accepts command
//  O_WriteBackRegIdx  out  4              scalar write index
//  O_WriteBackVRegIdx out  VREG_ID_WIDTH  vector write index
//  O_WriteBackData    out  REG_WIDTH      scalar write data
//  O_VecDestValue     out  VREG_WIDTH     vector write data
//  O_RegWEn/O_VRegWEn out  1 each         one-cycle write strobes
//  O_CCValue          out  3              CC {N,Z,P}
//  O_CCWEn            out  1              one-cycle CC update strobe
//  O_WriteBackPC      out  PC_WIDTH       redirect target
//  O_WriteBackPCEn    out  1              one-cycle redirect strobe
//  O_GPUCmdValid      out  1              GPU command valid
//  O_GPUCmd           out  40             {IR[31:24], VecData[31:0]}; held stable while valid
//  O_GPUStallSignal   out  1              stall to Decode/Fetch (combinational)
//  O_RetireCount      out  CNT_WIDTH      retired instructions, wraps
// BEHAVIOUR
//  - Reset (I_RESET_N=0 at negedge): all outputs 0 except O_CCValue=3'b010 (Z); FSM->IDLE; count 0.
//    Reset overrides I_LOCK and aborts an outstanding GPU command (valid 0 after that edge).
//  - Retire (I_LOCK & I_MW_Valid & IDLE & non-GPU op): outputs reflect it after the next negedge.
//    Latency 1 cycle; every strobe high exactly one cycle, then 0 unless another retire follows.
//    O_RegWEn=I_DestWrite, O_VRegWEn=I_DestVWrite, O_CCWEn=I_CCWrite, O_WriteBackPCEn=I_BranchTaken.
//  - CC: Data[REG_WIDTH-1]=1 -> 3'b100; Data==0 -> 3'b010; else 3'b001. Held when O_CCWEn=0.
//  - Simultaneous reg write + redirect (JSR/JSRR link) asserted in the same cycle; both legal.
//  - FSM IDLE->ISSUE on valid GPU-class op; O_GPUCmdValid=1 and payload latched in ISSUE.
//    ISSUE->IDLE at the negedge sampling I_GPUCmdReady=1. Ready sampled 1 on first ISSUE cycle
//    allowed (1-cycle command). GPU ops assert no RF/CC strobes.
//  - O_GPUStallSignal = (state==ISSUE) | (I_MW_Valid & is_gpu_op(I_IR)). Stays low when IDLE and no GPU op.
//  - I_MW_Valid while in ISSUE is a protocol error: ignored; assertion fires.
//  - O_RetireCount +1 per non-GPU retire and per GPU handshake; wraps all-ones -> 0.
//  - I_LOCK=0: strobes 0, FSM/payload/count held, O_GPUCmdValid held.
// STRUCTURE
//  - Package gpu_pipe_pkg: CC encodings (CC_N/CC_Z/CC_P), wb_state_e {IDLE,ISSUE},
//    function is_gpu_op(ir), GPU command width.
//  - One sub-module: wb_cc_gen (REG_WIDTH data -> 3-bit CC), combinational, reused by CMP path.
// TESTING
//  1 ADD R1: Data=16'h0005, DestWrite=1, CCWrite=1 -> next cycle RegWEn=1, idx=1, data=5, CC=001; cycle after RegWEn=0.
//  2 Data=16'h8000 -> CC=100; Data=0 -> CC=010; CCWrite=0 -> CC unchanged, CCWEn=0.
//  3 JSR: DestWrite=1 idx=7, BranchTaken=1, BranchPC=16'h0040 -> RegWEn & PCEn same cycle, PC=0x0040.
//  4 GPU op, Ready low 3 cycles -> Valid/Stall high 4 cycles, payload constant; count +1 on handshake only.
//  5 Reset asserted while in ISSUE -> next negedge Valid=0, Stall=0, count=0, CC=010.
//  6 Count preset near wrap via 2^CNT_WIDTH retires (CNT_WIDTH=4 build): 15 -> 0; I_LOCK=0 for 2 cycles holds all.

Source files
------------

// File: rtl/gpu_pipe_pkg.sv
// Shared definitions for the GPU core pipeline: condition-code encodings,
// writeback FSM states and GPU-op classification.
package gpu_pipe_pkg;

   localparam logic [2:0] CC_N = 3'b100;
   localparam logic [2:0] CC_Z = 3'b010;
   localparam logic [2:0] CC_P = 3'b001;

   localparam int unsigned GPU_CMD_WIDTH = 40;

   // Opcodes whose top nibble is 4'hF are GPU-class commands
   localparam logic [3:0] GPU_OP_CLASS = 4'hF;

   typedef enum logic {
      IDLE,
      ISSUE
   } wb_state_e;

   function automatic logic is_gpu_op(input logic [31:0] ir);
      return (ir[31:28] == GPU_OP_CLASS);
   endfunction

endpackage

// File: rtl/wb_cc_gen.sv
// Condition-code generator: classifies a result as negative, zero or positive.
module wb_cc_gen
   import gpu_pipe_pkg::*;
#(
   parameter int unsigned REG_WIDTH = 16
) (
   input  logic [REG_WIDTH-1:0] data,
   output logic [2:0]           cc
);

   always_comb begin
      cc = CC_P;
      if (data[REG_WIDTH-1]) begin
         cc = CC_N;
      end else if (data == '0) begin
         cc = CC_Z;
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: latches Memory-stage results, drives register/CC/PC write ports,
// issues GPU commands over valid/ready and counts retired instructions.
module writeback_stage
   import gpu_pipe_pkg::*;
#(
   parameter int unsigned REG_WIDTH     = 16,
   parameter int unsigned VREG_WIDTH    = 64,
   parameter int unsigned VREG_ID_WIDTH = 6,
   parameter int unsigned PC_WIDTH      = 16,
   parameter int unsigned CNT_WIDTH     = 32
) (
   input  logic                     I_CLOCK,
   input  logic                     I_RESET_N,
   input  logic                     I_LOCK,
   input  logic                     I_MW_Valid,
   input  logic [31:0]              I_IR,
   input  logic [3:0]               I_DestRegIdx,
   input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
   input  logic                     I_DestWrite,
   input  logic                     I_DestVWrite,
   input  logic                     I_CCWrite,
   input  logic [REG_WIDTH-1:0]     I_Data,
   input  logic [VREG_WIDTH-1:0]    I_VecData,
   input  logic                     I_BranchTaken,
   input  logic [PC_WIDTH-1:0]      I_BranchPC,
   input  logic                     I_GPUCmdReady,
   output logic [3:0]               O_WriteBackRegIdx,
   output logic [VREG_ID_WIDTH-1:0] O_WriteBackVRegIdx,
   output logic [REG_WIDTH-1:0]     O_WriteBackData,
   output logic [VREG_WIDTH-1:0]    O_VecDestValue,
   output logic                     O_RegWEn,
   output logic                     O_VRegWEn,
   output logic [2:0]               O_CCValue,
   output logic                     O_CCWEn,
   output logic [PC_WIDTH-1:0]      O_WriteBackPC,
   output logic                     O_WriteBackPCEn,
   output logic                     O_GPUCmdValid,
   output logic [GPU_CMD_WIDTH-1:0] O_GPUCmd,
   output logic                     O_GPUStallSignal,
   output logic [CNT_WIDTH-1:0]     O_RetireCount
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   wb_state_e state, next_state;
   logic      retire, issue, handshake;
   logic      gpu_op;
   logic [2:0] cc_new;
   logic      unused_ir;

   // Low IR bits carry no writeback information
   assign unused_ir = ^I_IR[23:0];
   assign gpu_op    = is_gpu_op(I_IR);

   wb_cc_gen #(.REG_WIDTH(REG_WIDTH)) u_cc_gen (
      .data (I_Data),
      .cc   (cc_new)
   );

   always_ff @(negedge I_CLOCK) begin
      if (!I_RESET_N) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      retire     = 1'b0;
      issue      = 1'b0;
      handshake  = 1'b0;
      case (state)
         IDLE: begin
            if (I_LOCK && I_MW_Valid) begin
               if (gpu_op) begin
                  issue      = 1'b1;
                  next_state = ISSUE;
               end else begin
                  retire = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (I_LOCK && I_GPUCmdReady) begin
               handshake  = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(negedge I_CLOCK) begin
      if (!I_RESET_N) begin
         O_WriteBackRegIdx  <= '0;
         O_WriteBackVRegIdx <= '0;
         O_WriteBackData    <= '0;
         O_VecDestValue     <= '0;
         O_RegWEn           <= 1'b0;
         O_VRegWEn          <= 1'b0;
         O_CCValue          <= CC_Z;
         O_CCWEn            <= 1'b0;
         O_WriteBackPC      <= '0;
         O_WriteBackPCEn    <= 1'b0;
         O_GPUCmd           <= '0;
         O_RetireCount      <= '0;
      end else begin
         O_RegWEn        <= retire & I_DestWrite;
         O_VRegWEn       <= retire & I_DestVWrite;
         O_CCWEn         <= retire & I_CCWrite;
         O_WriteBackPCEn <= retire & I_BranchTaken;
         if (retire) begin
            O_WriteBackRegIdx  <= I_DestRegIdx;
            O_WriteBackVRegIdx <= I_DestVRegIdx;
            O_WriteBackData    <= I_Data;
            O_VecDestValue     <= I_VecData;
            O_WriteBackPC      <= I_BranchPC;
         end
         if (retire && I_CCWrite) begin
            O_CCValue <= cc_new;
         end
         if (issue) begin
            O_GPUCmd <= {I_IR[31:24], I_VecData[31:0]};
         end
         if (retire || handshake) begin
            O_RetireCount <= O_RetireCount + CNT_ONE;
         end
      end
   end

   assign O_GPUCmdValid    = (state == ISSUE);
   assign O_GPUStallSignal = (state == ISSUE) | (I_MW_Valid & gpu_op);

   // Memory stage must not present a new instruction while a command is outstanding
   a_no_valid_in_issue: assert property (
      @(negedge I_CLOCK) disable iff (!I_RESET_N) (state == ISSUE) |-> !I_MW_Valid);

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage (CNT_WIDTH=4 build to exercise counter wrap).
module tb_writeback_stage;

   logic        clk;
   logic        rst_n;
   logic        lock;
   logic        mw_valid;
   logic [31:0] ir;
   logic [3:0]  dest_idx;
   logic [5:0]  dest_vidx;
   logic        dest_write;
   logic        dest_vwrite;
   logic        cc_write;
   logic [15:0] data;
   logic [63:0] vec_data;
   logic        br_taken;
   logic [15:0] br_pc;
   logic        gpu_ready;

   logic [3:0]  wb_idx;
   logic [5:0]  wb_vidx;
   logic [15:0] wb_data;
   logic [63:0] wb_vec;
   logic        reg_wen;
   logic        vreg_wen;
   logic [2:0]  cc_value;
   logic        cc_wen;
   logic [15:0] wb_pc;
   logic        pc_en;
   logic        cmd_valid;
   logic [39:0] cmd;
   logic        stall;
   logic [3:0]  retire_cnt;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        regwen;
      logic [3:0]  idx;
      logic [15:0] data;
      logic        vregwen;
      logic [5:0]  vidx;
      logic [63:0] vdata;
      logic        ccwen;
      logic [2:0]  cc;
      logic        pcen;
      logic [15:0] pc;
      logic [3:0]  cnt;
   } wb_t;

   typedef struct packed {
      logic [39:0] cmd;
      logic [7:0]  cycles;
      logic [3:0]  cnt_before;
      logic [3:0]  cnt_after;
   } gpu_t;

   wb_t  rq[$];
   gpu_t gq[$];
   logic [3:0] model_cnt = '0;

   writeback_stage #(.CNT_WIDTH(4)) dut (
      .I_CLOCK            (clk),
      .I_RESET_N          (rst_n),
      .I_LOCK             (lock),
      .I_MW_Valid         (mw_valid),
      .I_IR               (ir),
      .I_DestRegIdx       (dest_idx),
      .I_DestVRegIdx      (dest_vidx),
      .I_DestWrite        (dest_write),
      .I_DestVWrite       (dest_vwrite),
      .I_CCWrite          (cc_write),
      .I_Data             (data),
      .I_VecData          (vec_data),
      .I_BranchTaken      (br_taken),
      .I_BranchPC         (br_pc),
      .I_GPUCmdReady      (gpu_ready),
      .O_WriteBackRegIdx  (wb_idx),
      .O_WriteBackVRegIdx (wb_vidx),
      .O_WriteBackData    (wb_data),
      .O_VecDestValue     (wb_vec),
      .O_RegWEn           (reg_wen),
      .O_VRegWEn          (vreg_wen),
      .O_CCValue          (cc_value),
      .O_CCWEn            (cc_wen),
      .O_WriteBackPC      (wb_pc),
      .O_WriteBackPCEn    (pc_en),
      .O_GPUCmdValid      (cmd_valid),
      .O_GPUCmd           (cmd),
      .O_GPUStallSignal   (stall),
      .O_RetireCount      (retire_cnt)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sync();
      @(negedge clk);
      #1;
   endtask

   task automatic retire(input logic [15:0] d, input logic [3:0] idx, input logic dw,
                         input logic [5:0] vidx, input logic [63:0] vd, input logic vw,
                         input logic ccw, input logic [2:0] exp_cc,
                         input logic bt, input logic [15:0] pc);
      wb_t e;
      mw_valid = 1'b1; ir = 32'h1200_0000; data = d; dest_idx = idx; dest_write = dw;
      dest_vidx = vidx; vec_data = vd; dest_vwrite = vw; cc_write = ccw;
      br_taken = bt; br_pc = pc;
      model_cnt = model_cnt + 4'd1;
      e.regwen = dw; e.idx = idx; e.data = d; e.vregwen = vw; e.vidx = vidx; e.vdata = vd;
      e.ccwen = ccw; e.cc = exp_cc; e.pcen = bt; e.pc = pc; e.cnt = model_cnt;
      rq.push_back(e);
      sync();
      mw_valid = 1'b0; dest_write = 1'b0; dest_vwrite = 1'b0; cc_write = 1'b0; br_taken = 1'b0;
   endtask

   task automatic gpu_issue(input logic [31:0] irv, input logic [63:0] vd,
                            input logic [7:0] cycles, input logic [3:0] cnt_after);
      gpu_t g;
      mw_valid = 1'b1; ir = irv; vec_data = vd;
      dest_write = 1'b1; cc_write = 1'b1; br_taken = 1'b1;
      g.cmd = {irv[31:24], vd[31:0]}; g.cycles = cycles;
      g.cnt_before = model_cnt; g.cnt_after = cnt_after;
      gq.push_back(g);
      @(posedge clk);
      check("stall_on_gpu_op", {127'd0, stall}, 128'd1);
      sync();
      mw_valid = 1'b0; dest_write = 1'b0; cc_write = 1'b0; br_taken = 1'b0;
   endtask

   // Retire monitor: any write strobe consumes one expected writeback
   wb_t act_r, exp_r;
   always @(posedge clk) begin
      if (rst_n === 1'b1 && (reg_wen | vreg_wen | cc_wen | pc_en) === 1'b1) begin
         act_r.regwen = reg_wen; act_r.idx = wb_idx; act_r.data = wb_data;
         act_r.vregwen = vreg_wen; act_r.vidx = wb_vidx; act_r.vdata = wb_vec;
         act_r.ccwen = cc_wen; act_r.cc = cc_value; act_r.pcen = pc_en; act_r.pc = wb_pc;
         act_r.cnt = retire_cnt;
         if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_strobe: got %h expected none", act_r);
         end else begin
            exp_r = rq.pop_front();
            check("retire", 128'(act_r), 128'(exp_r));
         end
      end
   end

   // GPU monitor: checks payload/stall/count while valid, length and count when it drops
   logic prev_valid = 1'b0;
   int   vcyc = 0;
   gpu_t gexp;
   always @(posedge clk) begin
      if (cmd_valid === 1'b1) begin
         if (gq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_gpu_cmd: got %h expected none", cmd);
         end else begin
            check("gpu_cmd", 128'(cmd), 128'(gq[0].cmd));
            check("gpu_stall", {127'd0, stall}, 128'd1);
            check("gpu_cnt_hold", 128'(retire_cnt), 128'(gq[0].cnt_before));
         end
         vcyc++;
      end else if (prev_valid === 1'b1) begin
         if (gq.size() != 0) begin
            gexp = gq.pop_front();
            check("gpu_valid_cycles", 128'(vcyc), 128'(gexp.cycles));
            check("gpu_cnt_after", 128'(retire_cnt), 128'(gexp.cnt_after));
         end
         vcyc = 0;
      end
      prev_valid = cmd_valid;
   end

   initial begin
      rst_n = 1'b0; lock = 1'b0; mw_valid = 1'b0; ir = '0; dest_idx = '0; dest_vidx = '0;
      dest_write = 1'b0; dest_vwrite = 1'b0; cc_write = 1'b0; data = '0; vec_data = '0;
      br_taken = 1'b0; br_pc = '0; gpu_ready = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      check("reset_strobes", 128'({reg_wen, vreg_wen, cc_wen, pc_en, cmd_valid, stall}), 128'd0);
      check("reset_cc", 128'(cc_value), 128'(3'b010));
      check("reset_values", 128'({wb_idx, wb_vidx, wb_data, wb_pc, retire_cnt}), 128'd0);
      check("reset_cmd", 128'(cmd), 128'd0);
      sync();
      rst_n = 1'b1; lock = 1'b1;

      // ADD R1 <- 5
      retire(16'h0005, 4'd1, 1'b1, 6'd0, 64'd0, 1'b0, 1'b1, 3'b001, 1'b0, 16'h0);
      @(posedge clk);
      @(posedge clk);
      check("add_strobe_off", 128'({reg_wen, cc_wen}), 128'd0);
      sync();

      // CC negative, zero, then CC held when not written
      retire(16'h8000, 4'd2, 1'b1, 6'd0, 64'd0, 1'b0, 1'b1, 3'b100, 1'b0, 16'h0);
      retire(16'h0000, 4'd2, 1'b1, 6'd0, 64'd0, 1'b0, 1'b1, 3'b010, 1'b0, 16'h0);
      retire(16'h0001, 4'd3, 1'b1, 6'd0, 64'd0, 1'b0, 1'b0, 3'b010, 1'b0, 16'h0);
      @(posedge clk);
      @(posedge clk);
      check("cc_held", 128'(cc_value), 128'(3'b010));
      sync();

      // JSR link write with redirect, then a vector write
      retire(16'h0011, 4'd7, 1'b1, 6'd0, 64'd0, 1'b0, 1'b0, 3'b010, 1'b1, 16'h0040);
      retire(16'h0000, 4'd0, 1'b0, 6'd5, 64'h1122_3344_5566_7788, 1'b1, 1'b0, 3'b010, 1'b0, 16'h0);

      // GPU command with ready low for 3 cycles
      gpu_ready = 1'b0;
      gpu_issue(32'hF1AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D, 8'd4, 4'd7);
      repeat (3) sync();
      gpu_ready = 1'b1;
      sync();
      gpu_ready = 1'b0;
      model_cnt = 4'd7;
      @(posedge clk);
      #1;
      check("stall_idle_low", {127'd0, stall}, 128'd0);
      sync();

      // Reset while a command is outstanding
      gpu_issue(32'hF200_0000, 64'h0000_0000_1234_5678, 8'd3, 4'd0);
      repeat (2) sync();
      rst_n = 1'b0;
      sync();
      model_cnt = 4'd0;
      @(posedge clk);
      check("abort_valid_stall", 128'({cmd_valid, stall}), 128'd0);
      check("abort_cnt", 128'(retire_cnt), 128'd0);
      check("abort_cc", 128'(cc_value), 128'(3'b010));
      sync();
      rst_n = 1'b1;

      // Counter wrap through 16 retires
      for (int i = 0; i < 16; i++) begin
         retire(16'(i + 1), 4'(i), 1'b1, 6'd0, 64'd0, 1'b0, 1'b1, 3'b001, 1'b0, 16'h0);
      end

      // Lock low for two cycles with a retire-able instruction presented
      lock = 1'b0; mw_valid = 1'b1; ir = 32'h1200_0000; data = 16'h8000;
      dest_write = 1'b1; cc_write = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         @(posedge clk);
         check("lock_strobes", 128'({reg_wen, vreg_wen, cc_wen, pc_en, stall}), 128'd0);
         check("lock_cnt", 128'(retire_cnt), 128'd0);
         check("lock_cc", 128'(cc_value), 128'(3'b001));
      end
      #1;
      mw_valid = 1'b0; dest_write = 1'b0; cc_write = 1'b0; lock = 1'b1;
      sync();

      // Lock low holds an outstanding command even with ready high
      gpu_issue(32'hF300_0000, 64'h0000_0000_0BAD_F00D, 8'd3, 4'd1);
      lock = 1'b0; gpu_ready = 1'b1;
      repeat (2) sync();
      lock = 1'b1;
      sync();
      gpu_ready = 1'b0;
      model_cnt = 4'd1;

      for (int i = 0; i < 20 && (rq.size() != 0 || gq.size() != 0); i++) @(posedge clk);
      repeat (2) @(posedge clk);
      check("queues_drained", 128'(rq.size() + gq.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
